// File: rtl/lc3b_fetch_unit.sv
// LC-3b fetch stage: owns the fetch PC, runs the imem read/resp handshake and queues {pc, inst} for decode.
// Optional FETCH_PERF_CNT_EN adds the perf_fetched / perf_dropped saturating counters.
module lc3b_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_dropped
`endif
);
  // state | meaning
  // FETCH | read in flight at fetch_pc, responses are pushed
  // HOLD  | FIFO full, no request issued
  // DROP  | wrong-path read still in flight, its response is discarded
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [15:0]   pending_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [15:0]   fifo_pc   [DEPTH];
  logic [15:0]   fifo_inst [DEPTH];
  logic          push;
  logic          pop;
  logic [15:0]   redirect_pc_al;

  assign redirect_pc_al = redirect_pc & 16'hFFFE;
  assign push           = (state == FETCH) && imem_resp && !redirect_valid;
  assign pop            = inst_valid && !stall && !redirect_valid;

  assign imem_read    = !reset && (state != HOLD);
  assign imem_address = fetch_pc;
  assign inst_valid   = (count != '0);
  assign inst         = inst_valid ? fifo_inst[rd_ptr] : 16'h0000;
  assign pc           = inst_valid ? fifo_pc[rd_ptr] : 16'h0000;

  always_comb begin
    count_next = count;
    if (redirect_valid)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      pending_pc <= 16'h0000;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      count <= count_next;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end

      case (state)
        FETCH: begin
          if (redirect_valid) begin
            if (imem_resp) begin
              fetch_pc <= redirect_pc_al;
            end else begin
              pending_pc <= redirect_pc_al;
              state      <= DROP;
            end
          end else if (imem_resp) begin
            fetch_pc <= fetch_pc + 16'd2;
            if (count_next == CW'(DEPTH)) state <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc_al;
            state    <= FETCH;
          end else if (count_next < CW'(DEPTH)) begin
            state <= FETCH;
          end
        end
        DROP: begin
          // The latest redirect wins, even when it lands on the response cycle.
          if (imem_resp) begin
            fetch_pc <= redirect_valid ? redirect_pc_al : pending_pc;
            state    <= FETCH;
          end else if (redirect_valid) begin
            pending_pc <= redirect_pc_al;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_inst[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic drop_event;
  assign drop_event = imem_resp && ((state == DROP) || ((state == FETCH) && redirect_valid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 16'h0000;
      perf_dropped <= 16'h0000;
    end else begin
      if (push && (perf_fetched != 16'hFFFF))       perf_fetched <= perf_fetched + 16'd1;
      if (drop_event && (perf_dropped != 16'hFFFF)) perf_dropped <= perf_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Bench for lc3b_fetch_unit: memory responder with variable latency, queue scoreboard of {pc, inst}.
// A second instance with RESET_PC=16'hFFFE shares all inputs to exercise the PC wrap after reset.
module tb_lc3b_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] pc;
  logic [15:0] wrap_address;
  logic        wrap_read;
  logic        wrap_valid;
  logic [15:0] wrap_inst;
  logic [15:0] wrap_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_dropped, wrap_fetched, wrap_dropped;
`endif

  always #5 clk = ~clk;

  lc3b_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .imem_address(imem_address), .imem_read(imem_read),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .inst_valid(inst_valid), .inst(inst), .pc(pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  lc3b_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .imem_address(wrap_address), .imem_read(wrap_read),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .inst_valid(wrap_valid), .inst(wrap_inst), .pc(wrap_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(wrap_fetched), .perf_dropped(wrap_dropped)
`endif
  );

  int          checks = 0;
  int          passes = 0;
  logic [31:0] q[$];
  logic [15:0] exp_addr, pend, mem_addr;
  logic [15:0] exp_fetched, exp_dropped;
  bit          drop, mem_busy;
  int          mem_cnt, mem_lat, wrap_starts;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1261;
      16'h0002: return 16'h5020;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  // Scoreboard update for the edge that just consumed the current inputs.
  task automatic model_update();
    logic [15:0] rpc;
    rpc = redirect_pc & 16'hFFFE;
    if (redirect_valid) begin
      q.delete();
      if (imem_resp) begin
        exp_addr = rpc;
        drop = 1'b0;
        exp_dropped += 16'd1;
      end else if (mem_busy) begin
        drop = 1'b1;
        pend = rpc;
      end else begin
        exp_addr = rpc;
      end
    end else begin
      if (!stall && q.size() != 0) void'(q.pop_front());
      if (imem_resp) begin
        if (drop) begin
          exp_addr = pend;
          drop = 1'b0;
          exp_dropped += 16'd1;
        end else begin
          q.push_back({exp_addr, mem_word(exp_addr)});
          exp_addr += 16'd2;
          exp_fetched += 16'd1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] head;
    logic        exp_read;
    head = (q.size() != 0) ? q[0] : 32'h0;
    exp_read = (mem_busy && !imem_resp) || (q.size() < DEPTH);
    chk("inst_valid", 16'(inst_valid), 16'(q.size() != 0));
    chk("inst", inst, head[15:0]);
    chk("pc", pc, head[31:16]);
    chk("imem_read", 16'(imem_read), 16'(exp_read));
    chk("wrap_read", 16'(wrap_read), 16'(exp_read));
    chk("wrap_valid", 16'(wrap_valid), 16'(q.size() != 0));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, exp_fetched);
    chk("perf_dropped", perf_dropped, exp_dropped);
`endif
  endtask

  // Memory responder: latches a request, answers after mem_lat extra cycles.
  task automatic mem_model();
    logic [15:0] wexp;
    if (imem_resp) begin
      mem_busy = 1'b0;
      imem_resp = 1'b0;
    end
    if (!mem_busy && imem_read) begin
      mem_busy = 1'b1;
      mem_cnt = mem_lat;
      mem_addr = imem_address;
      chk("start_addr", imem_address, exp_addr);
      if (wrap_starts < 2) begin
        wexp = 16'hFFFE + 16'(2 * wrap_starts);
        chk("wrap_addr", wrap_address, wexp);
      end
      wrap_starts++;
    end else if (mem_busy) begin
      chk("addr_hold", imem_address, exp_addr);
    end
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_resp = 1'b1;
        imem_rdata = mem_word(mem_addr);
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
    mem_model();
  endtask

  task automatic model_reset();
    q.delete();
    exp_addr = 16'h0000;
    pend = 16'h0000;
    drop = 1'b0;
    mem_busy = 1'b0;
    mem_cnt = 0;
    wrap_starts = 0;
    exp_fetched = 16'h0000;
    exp_dropped = 16'h0000;
  endtask

  task automatic redirect_once(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_resp = 1'b0; imem_rdata = 16'h0000; mem_lat = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_inst_valid", 16'(inst_valid), 16'h0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_imem_read", 16'(imem_read), 16'h0);
    reset = 1'b0;
    #1;
    mem_model();

    // Streaming with a response one cycle after each request.
    repeat (6) step();

    // Decode stall fills the FIFO; fetch must park and then resume in order.
    stall = 1'b1;
    repeat (6) step();
    stall = 1'b0;
    repeat (6) step();

    // Redirect while a slow read is pending: address holds, data is dropped.
    mem_lat = 3;
    for (int i = 0; i < 40 && !(mem_busy && !imem_resp); i++) step();
    chk("wait_open_a", 16'(mem_busy && !imem_resp), 16'h1);
    redirect_once(16'h3000);
    repeat (12) step();

    // Redirect coinciding with the response.
    mem_lat = 1;
    for (int i = 0; i < 40 && !imem_resp; i++) step();
    chk("wait_resp", 16'(imem_resp), 16'h1);
    redirect_once(16'h0040);
    repeat (8) step();

    // Two redirects while a read is pending: the later one wins.
    mem_lat = 3;
    for (int i = 0; i < 40 && !(mem_busy && !imem_resp); i++) step();
    chk("wait_open_b", 16'(mem_busy && !imem_resp), 16'h1);
    redirect_once(16'h1235);
    redirect_once(16'h2469);
    repeat (12) step();

    // Redirect from HOLD with an odd target.
    mem_lat = 1;
    stall = 1'b1;
    for (int i = 0; i < 40 && q.size() != DEPTH; i++) step();
    chk("wait_full", 16'(q.size()), 16'(DEPTH));
    redirect_once(16'h1235);
    stall = 1'b0;
    repeat (8) step();

    // Async reset in the middle of a transaction with data buffered.
    stall = 1'b1;
    for (int i = 0; i < 40 && !(q.size() != 0 && mem_busy && !imem_resp); i++) step();
    chk("wait_mid", 16'(q.size() != 0 && mem_busy && !imem_resp), 16'h1);
    reset = 1'b1;
    imem_resp = 1'b0;
    #1;
    chk("midrst_inst_valid", 16'(inst_valid), 16'h0);
    chk("midrst_imem_read", 16'(imem_read), 16'h0);
    chk("midrst_inst", inst, 16'h0000);
    chk("midrst_pc", pc, 16'h0000);
    model_reset();
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    mem_model();
    repeat (8) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
